stats_sample_scheduler: RTL and testbench

- Periodically sequences snapshot requests to NUM_PORTS Ethernet statistics collectors, one port at a time, over a req/ack handshake.
- Sits between the system timebase/config registers and the per-port stats collectors.
- Gives every collector a sample taken in the same round, stamped with a common round start time.
- Detects overrun (a period elapses while a round is still in progress) and per-port ack timeouts.

---
 rtl/stats_sched_pkg.sv | 26 ++
 rtl/stats_sample_scheduler_period_timer.sv | 36 +++
 rtl/stats_sample_scheduler.sv | 165 ++++++++++++++++
 tb/tb_stats_sample_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stats_sched_pkg.sv
// rtl/stats_sched_pkg.sv - shared types and width helpers for the stats sample scheduler
package stats_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SCAN,
    REQ,
    DONE
  } sched_state_t;

  localparam int DEFAULT_NUM_PORTS   = 4;
  localparam int DEFAULT_ACK_TIMEOUT = 255;
  localparam int DEFAULT_COUNT_WIDTH = 32;

  // Port index width, never narrower than one bit so a single-port build still has an index.
  function automatic int idx_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  // The ack wait counter only has to reach ACK_TIMEOUT-1 before the timeout fires.
  function automatic int tmo_width(input int ack_timeout);
    return (ack_timeout > 1) ? $clog2(ack_timeout) : 1;
  endfunction

endpackage

// File: rtl/stats_sample_scheduler_period_timer.sv
// rtl/stats_sample_scheduler_period_timer.sv - round start tick generator
module period_timer #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] period,
  output logic                   tick
);

  logic                   enable_q;
  logic [COUNT_WIDTH-1:0] count;

  // Tick on the enable rise, then every max(period,1) cycles; period is sampled at each reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q <= 1'b0;
      count    <= '0;
      tick     <= 1'b0;
    end else begin
      enable_q <= enable;
      if (!enable) begin
        count <= '0;
        tick  <= 1'b0;
      end else if (!enable_q || count <= COUNT_WIDTH'(1)) begin
        count <= period;
        tick  <= 1'b1;
      end else begin
        count <= count - COUNT_WIDTH'(1);
        tick  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stats_sample_scheduler.sv
// rtl/stats_sample_scheduler.sv - sequences per-port stats snapshot requests once per period
module stats_sample_scheduler
  import stats_sched_pkg::*;
#(
  parameter int NUM_PORTS   = DEFAULT_NUM_PORTS,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] period,
  input  logic [NUM_PORTS-1:0]   port_mask,
  input  logic [63:0]            current_time,
  input  logic                   clear_errors,
  output logic [NUM_PORTS-1:0]   sample_req,
  input  logic [NUM_PORTS-1:0]   sample_ack,
  output logic [63:0]            round_time,
  output logic [COUNT_WIDTH-1:0] round_count,
  output logic                   busy,
  output logic                   overrun,
  output logic [NUM_PORTS-1:0]   timeout_err
);

  localparam int IDX_W = idx_width(NUM_PORTS);
  localparam int TMO_W = tmo_width(ACK_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  sched_state_t           state, state_d;
  logic [IDX_W-1:0]       idx, idx_d;
  logic [NUM_PORTS-1:0]   mask_q, mask_d;
  logic [TMO_W-1:0]       tmo_cnt, tmo_d;
  logic [NUM_PORTS-1:0]   req_d;
  logic [63:0]            round_time_d;
  logic [COUNT_WIDTH-1:0] round_count_d;
  logic                   busy_d;
  logic                   overrun_d;
  logic [NUM_PORTS-1:0]   timeout_d;
  logic                   tick;
  logic                   port_ack;

  period_timer #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_period_timer (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .period(period),
    .tick  (tick)
  );

  assign port_ack = sample_ack[idx];

  // Register the scheduler state and every output so requests and status are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      mask_q      <= '0;
      tmo_cnt     <= '0;
      sample_req  <= '0;
      round_time  <= '0;
      round_count <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= '0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      mask_q      <= mask_d;
      tmo_cnt     <= tmo_d;
      sample_req  <= req_d;
      round_time  <= round_time_d;
      round_count <= round_count_d;
      busy        <= busy_d;
      overrun     <= overrun_d;
      timeout_err <= timeout_d;
    end
  end

  // Round sequencing; losing enable outside REQ abandons the round, inside REQ it waits for ack/timeout.
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    mask_d        = mask_q;
    tmo_d         = tmo_cnt;
    req_d         = sample_req;
    round_time_d  = round_time;
    round_count_d = round_count;
    busy_d        = busy;
    overrun_d     = overrun;
    timeout_d     = timeout_err;

    if (clear_errors) begin
      overrun_d = 1'b0;
      timeout_d = '0;
    end
    if (tick && state != IDLE) begin
      overrun_d = 1'b1;
    end

    case (state)
      IDLE: begin
        if (tick) begin
          state_d = START;
        end
      end
      START: begin
        if (!enable) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          round_time_d = current_time;
          mask_d       = port_mask;
          idx_d        = '0;
          busy_d       = 1'b1;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (mask_q[idx]) begin
          state_d = REQ;
          req_d   = NUM_PORTS'(1) << idx;
          tmo_d   = '0;
        end else if (idx == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx + IDX_W'(1);
        end
      end
      REQ: begin
        if (port_ack || tmo_cnt == TMO_LAST) begin
          if (!port_ack) begin
            timeout_d[idx] = 1'b1;
          end
          req_d = '0;
          if (!enable) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else if (idx == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
            idx_d   = idx + IDX_W'(1);
          end
        end else begin
          tmo_d = tmo_cnt + TMO_W'(1);
        end
      end
      DONE: begin
        round_count_d = round_count + COUNT_WIDTH'(1);
        busy_d        = 1'b0;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stats_sample_scheduler.sv
// tb/tb_stats_sample_scheduler.sv - self-checking bench for stats_sample_scheduler
module tb_stats_sample_scheduler;

  localparam int NP = 4;
  localparam int AT = 10;
  localparam int CW = 8;
  localparam logic [63:0] TBASE = 64'h0000_1234_0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [CW-1:0] period = '0;
  logic [NP-1:0] port_mask = '0;
  logic [63:0]   current_time = TBASE;
  logic          clear_errors = 1'b0;
  logic [NP-1:0] sample_req;
  logic [NP-1:0] sample_ack = '0;
  logic [63:0]   round_time;
  logic [CW-1:0] round_count;
  logic          busy;
  logic          overrun;
  logic [NP-1:0] timeout_err;

  int errors = 0;
  int checks = 0;
  int ncyc = 0;

  stats_sample_scheduler #(
    .NUM_PORTS  (NP),
    .ACK_TIMEOUT(AT),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .period      (period),
    .port_mask   (port_mask),
    .current_time(current_time),
    .clear_errors(clear_errors),
    .sample_req  (sample_req),
    .sample_ack  (sample_ack),
    .round_time  (round_time),
    .round_count (round_count),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // timebase: after edge k current_time reads TBASE + k
  always @(posedge clk) begin
    #1;
    ncyc = ncyc + 1;
    current_time = TBASE + 64'(ncyc);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- collector responder ----------------
  int            ack_delay = 2;
  logic [NP-1:0] never_ack = '0;
  bit            noise = 0;
  int            rcnt[NP];

  always @(negedge clk) begin
    logic [NP-1:0] a;
    a = '0;
    for (int i = 0; i < NP; i++) begin
      if (sample_req[i]) begin
        rcnt[i]++;
        if (!never_ack[i] && rcnt[i] >= ack_delay) a[i] = 1'b1;
      end else begin
        rcnt[i] = 0;
        if (noise && $urandom_range(0, 3) == 0) a[i] = 1'b1;
      end
    end
    sample_ack = a;
  end

  // ---------------- request monitor ----------------
  int            rise_n[NP];
  int            first_rise[NP];
  int            last_len[NP];
  int            hi_len[NP];
  int            rise_q[$];
  logic [NP-1:0] prev_req = '0;

  always @(negedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (sample_req[i]) begin
        hi_len[i]++;
        if (!prev_req[i]) begin
          rise_n[i]++;
          rise_q.push_back(i);
          if (first_rise[i] < 0) first_rise[i] = ncyc;
        end
      end else if (hi_len[i] > 0) begin
        last_len[i] = hi_len[i];
        hi_len[i] = 0;
      end
    end
    prev_req = sample_req;
  end

  task automatic clear_mon();
    for (int i = 0; i < NP; i++) begin
      rise_n[i] = 0;
      first_rise[i] = -1;
      last_len[i] = 0;
    end
    rise_q.delete();
  endtask

  // ---------------- behavioural reference model ----------------
  logic [NP-1:0] e_req = '0, e_terr = '0;
  logic          e_busy = 0, e_ovr = 0;
  logic [63:0]   e_rt = '0;
  logic [CW-1:0] e_rc = '0;
  bit            m_idle = 1, abort = 0, tk = 0, t_tick = 0, t_enp = 0;
  int            t_since = 0, t_intv = 1;
  logic          s_en, s_clr;
  logic [NP-1:0] s_ack, s_mask;
  logic [63:0]   s_time;
  logic [CW-1:0] s_per;

  // one clock edge: sample inputs, advance the round timer, apply error clear/overrun
  task automatic cyc();
    @(posedge clk);
    abort = 0;
    s_en = enable; s_ack = sample_ack; s_clr = clear_errors;
    s_mask = port_mask; s_time = current_time; s_per = period;
    if (rst) begin
      e_req = '0; e_terr = '0; e_busy = 0; e_ovr = 0; e_rt = '0; e_rc = '0;
      m_idle = 1; abort = 1; tk = 0; t_tick = 0; t_enp = 0; t_since = 0;
      return;
    end
    tk = t_tick;
    if (!s_en) begin
      t_tick = 0;
    end else if (!t_enp) begin
      t_tick = 1; t_since = 0; t_intv = (s_per == 0) ? 1 : int'(s_per);
    end else begin
      t_since++;
      if (t_since >= t_intv) begin
        t_tick = 1; t_since = 0; t_intv = (s_per == 0) ? 1 : int'(s_per);
      end else begin
        t_tick = 0;
      end
    end
    t_enp = s_en;
    if (s_clr) begin
      e_ovr = 0;
      e_terr = '0;
    end
    if (tk && !m_idle) e_ovr = 1;
  endtask

  task automatic run_round();
    logic [NP-1:0] mask;
    int waited;
    m_idle = 0;
    cyc(); if (abort) return;
    if (!s_en) begin e_busy = 0; m_idle = 1; return; end
    e_rt = s_time; mask = s_mask; e_busy = 1;
    for (int i = 0; i < NP; i++) begin
      cyc(); if (abort) return;
      if (!s_en) begin e_busy = 0; m_idle = 1; return; end
      if (mask[i]) begin
        e_req = NP'(1) << i;
        waited = 0;
        forever begin
          cyc(); if (abort) return;
          waited++;
          if (s_ack[i]) break;
          if (waited == AT) begin e_terr[i] = 1'b1; break; end
        end
        e_req = '0;
        if (!s_en) begin e_busy = 0; m_idle = 1; return; end
      end
    end
    cyc(); if (abort) return;
    e_rc = e_rc + CW'(1);
    e_busy = 0;
    m_idle = 1;
  endtask

  initial begin
    forever begin
      cyc();
      if (!abort && tk && m_idle) run_round();
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("sample_req", 64'(sample_req), 64'(e_req));
      check("busy", 64'(busy), 64'(e_busy));
      check("round_time", round_time, e_rt);
      check("round_count", 64'(round_count), 64'(e_rc));
      check("overrun", 64'(overrun), 64'(e_ovr));
      check("timeout_err", 64'(timeout_err), 64'(e_terr));
      check("req_onehot", 64'($countones(sample_req) <= 1), 64'd1);
    end
  end

  task automatic wait_req(input logic [NP-1:0] m, input int limit);
    int n;
    n = 0;
    while ((sample_req & m) == '0 && n < limit) begin
      step(1);
      n++;
    end
    check("wait_req", 64'((sample_req & m) != '0), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    logic [CW-1:0] rc0;
    clear_mon();
    for (int i = 0; i < NP; i++) hi_len[i] = 0;

    step(2);
    check("rst_req", 64'(sample_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(round_count), 64'd0);
    check("rst_time", round_time, 64'd0);
    rst = 0;
    step(3);

    // all ports, ack after 2 cycles, period 100
    period = CW'(100); port_mask = 4'b1111; ack_delay = 2;
    clear_mon();
    c = ncyc;
    enable = 1;
    step(30);
    check("first_req_latency", 64'(first_rise[0]), 64'(c + 4));
    check("rise_count", 64'(rise_q.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++) check("rise_order", 64'((i < rise_q.size()) ? rise_q[i] : -1), 64'(i));
    check("count_round1", 64'(round_count), 64'd1);
    check("time_round1", round_time, TBASE + 64'(c + 2));
    check("idle_round1", 64'(busy), 64'd0);
    step(100);
    check("count_round2", 64'(round_count), 64'd2);
    check("time_round2", round_time, TBASE + 64'(c + 102));
    enable = 0;
    step(3);

    // sparse mask
    port_mask = 4'b1010;
    clear_mon();
    enable = 1;
    step(150);
    check("mask_p0", 64'(rise_n[0]), 64'd0);
    check("mask_p2", 64'(rise_n[2]), 64'd0);
    check("mask_p1", 64'(rise_n[1]), 64'd2);
    check("mask_p3", 64'(rise_n[3]), 64'd2);
    check("mask_count", 64'(round_count), 64'd4);
    enable = 0;
    step(3);

    // port 2 never acks
    port_mask = 4'b1111; never_ack = 4'b0100;
    clear_mon();
    enable = 1;
    step(60);
    check("tmo_len", 64'(last_len[2]), 64'(AT));
    check("tmo_err", 64'(timeout_err), 64'b0100);
    check("tmo_p3_sampled", 64'(rise_n[3]), 64'd1);
    check("tmo_count", 64'(round_count), 64'd5);
    clear_errors = 1;
    step(1);
    clear_errors = 0;
    check("tmo_cleared", 64'(timeout_err), 64'd0);
    enable = 0; never_ack = '0;
    step(3);

    // overrun: period shorter than a round
    period = CW'(5); ack_delay = 8;
    enable = 1;
    step(120);
    check("overrun_set", 64'(overrun), 64'd1);
    enable = 0;
    step(50);
    check("overrun_no_tmo", 64'(timeout_err), 64'd0);
    check("overrun_idle", 64'(busy), 64'd0);
    clear_errors = 1;
    step(1);
    clear_errors = 0;
    check("overrun_cleared", 64'(overrun), 64'd0);

    // enable dropped while port 1 is being sampled
    period = CW'(100); ack_delay = 6;
    enable = 1;
    wait_req(4'b0010, 60);
    rc0 = e_rc;
    enable = 0;
    clear_mon();
    step(30);
    check("drop_req1_len", 64'(last_len[1]), 64'd6);
    check("drop_no_req2", 64'(rise_n[2]), 64'd0);
    check("drop_no_req3", 64'(rise_n[3]), 64'd0);
    check("drop_count", 64'(round_count), 64'(rc0));
    check("drop_busy", 64'(busy), 64'd0);

    // randomized segments
    noise = 1;
    for (int seg = 0; seg < 14; seg++) begin
      int len;
      period = CW'($urandom_range(0, 24));
      port_mask = NP'($urandom);
      ack_delay = $urandom_range(1, 13);
      never_ack = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
      enable = ($urandom_range(0, 4) != 0);
      len = $urandom_range(40, 220);
      for (int k = 0; k < len; k++) begin
        clear_errors = ($urandom_range(0, 30) == 0);
        if ($urandom_range(0, 60) == 0) enable = ~enable;
        if ($urandom_range(0, 80) == 0) port_mask = NP'($urandom);
        step(1);
      end
    end
    clear_errors = 0; noise = 0; never_ack = '0;

    // empty mask, back-to-back rounds: round_count wraps
    enable = 0;
    step(2);
    port_mask = '0; period = '0;
    enable = 1;
    step(1900);

    // asynchronous reset in the middle of a request
    enable = 0;
    step(3);
    port_mask = 4'b1111; period = CW'(100); ack_delay = 6;
    enable = 1;
    wait_req(4'b1111, 60);
    @(negedge clk);
    #1;
    rst = 1;
    #1;
    check("arst_req", 64'(sample_req), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_count", 64'(round_count), 64'd0);
    check("arst_overrun", 64'(overrun), 64'd0);
    check("arst_tmo", 64'(timeout_err), 64'd0);
    step(3);
    rst = 0;
    step(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
